tt_um_galaguna_nanosys_fit: RTL and testbench
=============================================

# tt_um_galaguna_nanosys_fit

Nano119 system top: a 4-bit-address, 8-bit-data accumulator CPU with a 16-byte unified program/data memory, wrapped in the standard Tiny Tapeout user-project pinout. A host loads memory through the dedicated inputs in load mode, then switches to run mode. In run mode the CPU executes from address 0 and drives its OUT register on `uo_out` and status flags on `uio_out[7:4]`.

## Interface
- No parameters.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: design enable. While 0, all registers and memory hold their values. Combinational outputs stay live.
- `ui_in` input 8:
  - [7] MODE: 0 = load, 1 = run.
  - [4] WE: level write enable, load mode only.
  - [3:0] ADDR: load/readback address.
  - [6:5] unused.
- `uio_in` input 8:
  - [7:0] write data in load mode.
  - [3:0] IN port in run mode.
- `uo_out` output 8:
  - Load mode: `mem[ADDR]`, combinational readback.
  - Run mode: OUT register.
- `uio_out` output 8:
  - [7] HALTED, [6] C, [5] Z, [4] RUNNING.
  - [3:0] = 0.
- `uio_oe` output 8: constant 8'hF0.

## Operation
- Storage:
  - mem[0..15], 8 bits each, flops.
  - ACC (8), C (1), PC (4), IR (8), OUT (8).
  - Z is combinational: Z = (ACC == 0).
- State machine states: IDLE, FETCH, EXEC, HALT.
- Transitions:
  - IDLE: MODE=1 → FETCH. While in IDLE with MODE=0, memory writes are enabled.
  - FETCH: IR ← mem[PC]; PC ← PC+1 (mod 16); → EXEC.
  - EXEC: execute IR; → FETCH, or → HALT on HLT.
  - HALT: stays in HALT until MODE=0.
  - Any state with MODE=0 → IDLE and PC ← 0. ACC, C and OUT are retained.
- Load write: on an edge with ena=1, state IDLE (or MODE=0), and WE=1, mem[ADDR] ← uio_in.
- Instruction format: IR[7:4] opcode, IR[3:0] operand `a`.
  - 0 NOP
  - 1 LDI: ACC ← {4'h0, a}
  - 2 LDA: ACC ← mem[a]
  - 3 STA: mem[a] ← ACC. Self-modification is allowed.
  - 4 ADD: {C, ACC} ← ACC + mem[a]
  - 5 SUB: ACC ← ACC − mem[a]; C ← borrow (1 if ACC < mem[a])
  - 6 AND, 7 OR, 8 XOR with mem[a]; C unchanged
  - 9 JMP: PC ← a
  - A JZ: if Z, PC ← a
  - B JC: if C, PC ← a
  - C OUT: OUT ← ACC
  - D IN: ACC ← {4'h0, uio_in[3:0]}
  - E SHL: C ← ACC[7]; ACC ← ACC << 1
  - F HLT
- Flags: C changes only on ADD, SUB and SHL. Z always reflects the current ACC.
- Status bits: RUNNING = state ∈ {FETCH, EXEC}; HALTED = state is HALT.

## Timing
- Reset values:
  - All registers and memory = 0; state = IDLE.
  - So `uo_out` = 8'h00, `uio_out` = 8'h20 (Z=1), `uio_oe` = 8'hF0.
- Every instruction takes 2 cycles (FETCH + EXEC). Entering run mode costs 1 cycle (IDLE → FETCH).
- A program of N instructions ending in HLT reaches HALT N·2+1 edges after MODE=1 is first sampled.
- Effect visibility:
  - An OUT result appears on `uo_out` after the EXEC edge.
  - A load write is visible on readback the cycle after the edge.
- PC wraps from 15 to 0; execution continues at 0 with no fault.
- MODE=0 in mid-instruction aborts it; the pending EXEC is not performed.
- Reset asserted mid-run clears everything immediately.
- WE with MODE=1 is ignored.

## Test plan
- Reset: assert rst_n=0 → `uo_out`=00, `uio_out`=20, `uio_oe`=F0, all readbacks = 00.
- Add program:
  - Load mem0=15, mem1=4F, mem2=C0, mem3=F0, memF=03.
  - Set MODE=1 → after 9 edges `uo_out`=08 and `uio_out[7]`=1.
- Countdown loop:
  - Load mem0=13, mem1=5E, mem2=C0, mem3=A5, mem4=91, mem5=F0, memE=01.
  - Expect OUT sequence 02, 01, 00, then HALTED=1, Z=1, C=0.
- Carry:
  - Load memD=FF; program 2D, 4D, B4, F0, mem4=C0, mem5=F0.
  - Expect jump taken; OUT=FE, C=1, halt.
- IN / mode abort:
  - Set uio_in=0A; program D0, C0, F0 → `uo_out`=0A.
  - Then drop MODE → RUNNING=0, readback mode active.
  - Re-run restarts at PC 0.
- ena=0 during run: state, PC and OUT are frozen for the held cycles. Execution resumes unchanged when ena returns to 1.

Source files
------------

// File: rtl/tt_um_galaguna_nanosys_fit.sv
// rtl/tt_um_galaguna_nanosys_fit.sv - Nano119 accumulator CPU with 16-byte memory in Tiny Tapeout pinout
//
// Purpose: 4-bit address / 8-bit data accumulator CPU. A host fills the
// unified program/data memory in load mode, then switches to run mode and
// the CPU executes from address 0.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      design enable; 0 freezes all registers and memory
//   ui_in    [7] mode (0 load, 1 run), [4] write enable, [3:0] address
//   uio_in   load mode: write data; run mode: [3:0] IN port
//   uo_out   load mode: mem[address] readback; run mode: OUT register
//   uio_out  [7] halted, [6] carry, [5] zero, [4] running, [3:0] zero
//   uio_oe   constant 8'hF0 (upper nibble driven as status)

module tt_um_galaguna_nanosys_fit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [7:0] mem [16];
  logic [7:0] acc;
  logic       carry;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [7:0] out_reg;
  logic [1:0] state;

  logic       mode;
  logic       we;
  logic [3:0] addr;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [7:0] operand_data;
  logic       zero;
  logic       running;
  logic       halted;
  logic       unused_bits;

  assign mode         = ui_in[7];
  assign we           = ui_in[4];
  assign addr         = ui_in[3:0];
  assign opcode       = ir[7:4];
  assign operand      = ir[3:0];
  assign operand_data = mem[operand];
  assign zero         = (acc == 8'h00);
  assign running      = (state == ST_FETCH) || (state == ST_EXEC);
  assign halted       = (state == ST_HALT);
  assign unused_bits  = &{1'b0, ui_in[6:5]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
      acc     <= 8'h00;
      carry   <= 1'b0;
      pc      <= 4'h0;
      ir      <= 8'h00;
      out_reg <= 8'h00;
      state   <= ST_IDLE;
    end else if (ena) begin
      if (!mode) begin
        // Load mode overrides every state: a pending EXEC is dropped and
        // the next run restarts at address 0. ACC, carry and OUT survive.
        state <= ST_IDLE;
        pc    <= 4'h0;
        if (we) begin
          mem[addr] <= uio_in;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_FETCH;
          end
          ST_FETCH: begin
            ir    <= mem[pc];
            pc    <= pc + 4'd1;
            state <= ST_EXEC;
          end
          ST_EXEC: begin
            state <= ST_FETCH;
            case (opcode)
              4'h1: acc <= {4'h0, operand};
              4'h2: acc <= operand_data;
              4'h3: mem[operand] <= acc;
              4'h4: {carry, acc} <= {1'b0, acc} + {1'b0, operand_data};
              4'h5: begin
                acc   <= acc - operand_data;
                carry <= (acc < operand_data);
              end
              4'h6: acc <= acc & operand_data;
              4'h7: acc <= acc | operand_data;
              4'h8: acc <= acc ^ operand_data;
              4'h9: pc <= operand;
              4'hA: if (zero) pc <= operand;
              4'hB: if (carry) pc <= operand;
              4'hC: out_reg <= acc;
              4'hD: acc <= {4'h0, uio_in[3:0]};
              4'hE: begin
                carry <= acc[7];
                acc   <= {acc[6:0], 1'b0};
              end
              4'hF: state <= ST_HALT;
              default: ;
            endcase
          end
          default: begin
            state <= ST_HALT;
          end
        endcase
      end
    end
  end

  assign uo_out  = mode ? out_reg : mem[addr];
  assign uio_out = {halted, carry, zero, running, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_galaguna_nanosys_fit.sv
// tb/tb_tt_um_galaguna_nanosys_fit.sv - directed self-checking bench for the Nano119 system top

module tb_tt_um_galaguna_nanosys_fit;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_errors;

  tt_um_galaguna_nanosys_fit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 time unit past the last one.
  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    ui_in  = {4'b0001, a};
    uio_in = d;
    run_edges(1);
    ui_in  = {4'b0000, a};
  endtask

  task automatic readback(input string tag, input logic [3:0] a, input logic [7:0] exp);
    ui_in = {4'b0000, a};
    #1;
    check_eq(tag, uo_out, exp);
  endtask

  task automatic to_load_mode();
    ui_in = 8'h00;
    run_edges(1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    run_edges(2);

    // Reset state
    check_eq("rst_uo_out", uo_out, 8'h00);
    check_eq("rst_uio_out", uio_out, 8'h20);
    check_eq("rst_uio_oe", uio_oe, 8'hF0);
    for (int i = 0; i < 16; i += 5) begin
      readback("rst_mem", 4'(i), 8'h00);
    end
    rst_n = 1'b1;
    run_edges(1);

    // Add program: LDI 5; ADD [F]=3; OUT; HLT -> 08 after 9 edges
    load(4'h0, 8'h15);
    load(4'h1, 8'h4F);
    load(4'h2, 8'hC0);
    load(4'h3, 8'hF0);
    load(4'hF, 8'h03);
    readback("add_load_rb", 4'hF, 8'h03);
    readback("add_load_rb0", 4'h0, 8'h15);
    ui_in = 8'h80;
    run_edges(8);
    check_eq("add_pre_halt_status", uio_out, 8'h10);
    check_eq("add_out_early", uo_out, 8'h08);
    run_edges(1);
    check_eq("add_out", uo_out, 8'h08);
    check_eq("add_halted", uio_out, 8'h80);
    to_load_mode();
    check_eq("add_idle_status", uio_out, 8'h00);

    // Countdown loop: OUT 02, 01, 00 then halt with Z=1, C=0
    load(4'h0, 8'h13);
    load(4'h1, 8'h5E);
    load(4'h2, 8'hC0);
    load(4'h3, 8'hA5);
    load(4'h4, 8'h91);
    load(4'h5, 8'hF0);
    load(4'hE, 8'h01);
    ui_in = 8'h80;
    run_edges(7);
    check_eq("cd_out_02", uo_out, 8'h02);
    run_edges(7);
    check_eq("cd_out_02_held", uo_out, 8'h02);
    run_edges(1);
    check_eq("cd_out_01", uo_out, 8'h01);
    run_edges(8);
    check_eq("cd_out_00", uo_out, 8'h00);
    run_edges(3);
    check_eq("cd_running_last", uio_out, 8'h30);
    run_edges(1);
    check_eq("cd_halted", uio_out, 8'hA0);
    run_edges(3);
    check_eq("cd_halt_sticky", uio_out, 8'hA0);
    to_load_mode();

    // Carry: FF+FF sets C, JC taken to OUT at 4
    load(4'hD, 8'hFF);
    load(4'h0, 8'h2D);
    load(4'h1, 8'h4D);
    load(4'h2, 8'hB4);
    load(4'h3, 8'hF0);
    load(4'h4, 8'hC0);
    load(4'h5, 8'hF0);
    ui_in = 8'h80;
    run_edges(9);
    check_eq("carry_out", uo_out, 8'hFE);
    run_edges(2);
    check_eq("carry_halted", uio_out, 8'hC0);
    to_load_mode();

    // IN port, readback on mode drop, abort, restart at PC 0
    load(4'h0, 8'hD0);
    load(4'h1, 8'hC0);
    load(4'h2, 8'hF0);
    uio_in = 8'h0A;
    ui_in  = 8'h80;
    run_edges(5);
    check_eq("in_out", uo_out, 8'h0A);
    run_edges(2);
    check_eq("in_halted", uio_out, 8'hC0);
    ui_in = 8'h01;
    #1;
    check_eq("in_readback_mode", uo_out, 8'hC0);
    run_edges(1);
    check_eq("in_not_running", uio_out, 8'h40);

    // WE in run mode must not write mem[2]; IN from 00 aborted before EXEC
    uio_in = 8'h00;
    ui_in  = 8'h92;
    run_edges(2);
    check_eq("abort_running", uio_out, 8'h50);
    ui_in = 8'h02;
    #1;
    check_eq("run_we_ignored", uo_out, 8'hF0);
    run_edges(1);
    check_eq("abort_no_exec", uio_out, 8'h40);
    uio_in = 8'h07;
    ui_in  = 8'h80;
    run_edges(5);
    check_eq("restart_pc0", uo_out, 8'h07);
    run_edges(2);
    to_load_mode();

    // ena=0 freezes state, PC and OUT mid-run
    uio_in = 8'h03;
    ui_in  = 8'h80;
    run_edges(3);
    ena = 1'b0;
    run_edges(5);
    check_eq("ena_hold_status", uio_out, 8'h50);
    check_eq("ena_hold_out", uo_out, 8'h07);
    ena = 1'b1;
    run_edges(2);
    check_eq("ena_resume_out", uo_out, 8'h03);
    run_edges(2);
    check_eq("ena_resume_halt", uio_out, 8'hC0);
    to_load_mode();

    // PC wrap F->0 plus self-modifying STA 0
    load(4'h0, 8'h9E);
    load(4'hE, 8'h19);
    load(4'hF, 8'h30);
    load(4'h9, 8'hC0);
    load(4'hA, 8'hF0);
    ui_in = 8'h80;
    run_edges(13);
    check_eq("wrap_out", uo_out, 8'h09);
    check_eq("wrap_halted", uio_out, 8'hC0);

    // Asynchronous reset mid-run clears registers immediately
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", uo_out, 8'h00);
    check_eq("async_rst_status", uio_out, 8'h20);
    ui_in = 8'h00;
    #1;
    check_eq("async_rst_mem0", uo_out, 8'h00);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
